boolean_lut_sweeper: RTL and testbench

Parametrised, registered successor to the team's fixed two-output four-input boolean circuits. The block holds each function in a writable truth table (LUT) and evaluates it for single input vectors through a valid/ready handshake. A sweep mode enumerates all 2^N_IN input combinations and streams every result, so a whole function can be checked exhaustively on-chip. It sits between a configuration master that loads the tables and a consumer such as a checker or logger.

---
 rtl/boolean_pkg.sv | 20 ++
 rtl/boolean_lut.sv | 49 ++++
 rtl/boolean_lut_sweeper.sv | 132 +++++++++++++
 tb/tb_boolean_lut_sweeper.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/boolean_pkg.sv
// ============================================================================
// boolean_pkg : shared FSM state type and LUT sizing helper.
// Rev 1.0
// ============================================================================
`default_nettype none

package boolean_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  function automatic int lut_depth(input int n);
    return 1 << n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/boolean_lut.sv
// ============================================================================
// boolean_lut : 2^N_IN x N_OUT truth-table register array, sync write / async read.
// Rev 1.0
// ============================================================================
`default_nettype none

module boolean_lut
  import boolean_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [N_IN-1:0]  wr_addr,
  input  logic [N_OUT-1:0] wr_data,
  input  logic [N_IN-1:0]  rd_addr,
  output logic [N_OUT-1:0] rd_data
);

  localparam int DEPTH = lut_depth(N_IN);

  logic [N_OUT-1:0] mem_q [DEPTH];
  logic [N_OUT-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read sees the pre-edge contents, so a same-cycle write is not forwarded.
  assign rd_data = mem_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/boolean_lut_sweeper.sv
// ============================================================================
// boolean_lut_sweeper : LUT-based boolean evaluator with exhaustive sweep mode.
// Rev 1.0
// ============================================================================
`default_nettype none

module boolean_lut_sweeper
  import boolean_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [N_IN-1:0]  cfg_addr,
  input  logic [N_OUT-1:0] cfg_data,
  input  logic             in_valid,
  input  logic [N_IN-1:0]  in_vec,
  output logic             in_ready,
  input  logic             sweep_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_IN-1:0]  out_vec,
  output logic [N_OUT-1:0] out_func,
  output logic             out_last,
  output logic             busy
);

  // Extra MSB keeps the terminal compare from aliasing with the wrapped count.
  localparam logic [N_IN:0] LAST_CNT = {1'b0, {N_IN{1'b1}}};

  state_e           state_q,     state_d;
  logic [N_IN:0]    cnt_q,       cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [N_IN-1:0]  out_vec_q,   out_vec_d;
  logic [N_OUT-1:0] out_func_q,  out_func_d;
  logic             out_last_q,  out_last_d;

  logic             is_idle;
  logic             slot_free;
  logic             accept;
  logic             sweep_load;
  logic             lut_we;
  logic [N_IN-1:0]  lut_rd_addr;
  logic [N_OUT-1:0] lut_rd_data;

  assign is_idle     = (state_q == ST_IDLE);
  assign slot_free   = !out_valid_q || out_ready;
  assign in_ready    = is_idle && slot_free && !sweep_start;
  assign accept      = in_valid && in_ready;
  assign sweep_load  = !is_idle && slot_free;
  assign lut_we      = cfg_we && is_idle;
  assign lut_rd_addr = is_idle ? in_vec : cnt_q[N_IN-1:0];

  boolean_lut #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_lut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (lut_we),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .rd_addr (lut_rd_addr),
    .rd_data (lut_rd_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sweep_start) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (sweep_load) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_vec_d   = out_vec_q;
    out_func_d  = out_func_q;
    out_last_d  = out_last_q;
    if (accept || sweep_load) begin
      out_valid_d = 1'b1;
      out_vec_d   = lut_rd_addr;
      out_func_d  = lut_rd_data;
      out_last_d  = sweep_load && (cnt_q == LAST_CNT);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
      out_func_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_vec_q   <= out_vec_d;
      out_func_q  <= out_func_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;
  assign out_func  = out_func_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == ST_SWEEP);

endmodule

`default_nettype wire

// File: tb/tb_boolean_lut_sweeper.sv
// ============================================================================
// tb_boolean_lut_sweeper : self-checking bench for boolean_lut_sweeper.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_boolean_lut_sweeper;

  logic       clk;
  logic       rst_n;
  logic       cfg_we, in_valid, sweep_start, out_ready;
  logic [3:0] cfg_addr, in_vec;
  logic [1:0] cfg_data;
  logic       in_ready, out_valid, out_last, busy;
  logic [3:0] out_vec;
  logic [1:0] out_func;

  logic       cfg_we_2, in_valid_2, sweep_start_2, out_ready_2;
  logic [1:0] cfg_addr_2, in_vec_2;
  logic [0:0] cfg_data_2;
  logic       in_ready_2, out_valid_2, out_last_2, busy_2;
  logic [1:0] out_vec_2;
  logic [0:0] out_func_2;

  int n_pass;
  int n_total;

  logic [1:0] model_lut [16];

  typedef struct {
    logic [3:0] vec;
    logic [1:0] exp;
  } vec_t;

  vec_t tbl [8];

  boolean_lut_sweeper #(.N_IN(4), .N_OUT(2)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_vec(in_vec), .in_ready(in_ready), .sweep_start(sweep_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_func(out_func),
    .out_last(out_last), .busy(busy)
  );

  boolean_lut_sweeper #(.N_IN(2), .N_OUT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we_2), .cfg_addr(cfg_addr_2), .cfg_data(cfg_data_2),
    .in_valid(in_valid_2), .in_vec(in_vec_2), .in_ready(in_ready_2), .sweep_start(sweep_start_2),
    .out_valid(out_valid_2), .out_ready(out_ready_2), .out_vec(out_vec_2), .out_func(out_func_2),
    .out_last(out_last_2), .busy(busy_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // E = A | BC | B'D (bit 1), F = B'C | BC'D' (bit 0), with A = MSB.
  function automatic logic [1:0] ref_func(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return {a | (b & c) | (!b & d), (!b & c) | (b & !c & !d)};
  endfunction

  task automatic eval4(input string nm, input logic [3:0] v, input logic [1:0] exp);
    in_valid = 1'b1;
    in_vec   = v;
    out_ready = 1'b1;
    #1;
    chk({nm, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_vec"}, out_vec, v);
    chk({nm, "_func"}, out_func, exp);
    chk({nm, "_last"}, out_last, 0);
    tick();
  endtask

  task automatic sweep4(input bit stall, input bit cfg_poke);
    int beats, cycles, busy_cnt, stalls;
    beats = 0; cycles = 0; busy_cnt = 0; stalls = 0;
    sweep_start = 1'b1;
    in_valid    = 1'b1;
    in_vec      = 4'h9;
    out_ready   = 1'b1;
    #1;
    chk("start_in_ready", in_ready, 0);
    tick();
    sweep_start = 1'b0;
    in_valid    = 1'b0;
    chk("busy_rise", busy, 1);
    while (cycles < 60) begin
      cfg_we   = cfg_poke && (cycles == 3);
      cfg_addr = 4'd3;
      cfg_data = 2'b00;
      if (busy) busy_cnt++;
      out_ready = 1'b1;
      if (stall && beats == 5 && stalls < 3) begin
        out_ready = 1'b0;
        stalls++;
        chk("stall_valid", out_valid, 1);
        chk("stall_vec", out_vec, 5);
      end
      if (out_valid && out_ready) begin
        chk("sweep_vec", out_vec, beats);
        chk("sweep_func", out_func, model_lut[beats]);
        chk("sweep_last", out_last, (beats == 15) ? 1 : 0);
        beats++;
        if (beats == 16) break;
      end
      tick();
      cycles++;
    end
    cfg_we = 1'b0;
    chk("sweep_beats", beats, 16);
    chk("sweep_cycles", cycles, stall ? 19 : 16);
    chk("busy_cycles", busy_cnt, stall ? 19 : 16);
    chk("busy_fall", busy, 0);
    tick();
    chk("sweep_drained", out_valid, 0);
  endtask

  initial begin
    logic [5:0] q_exp [$];
    logic [1:0] xor_exp [4];
    bit exp_free;
    int beats, waited;

    n_pass = 0; n_total = 0;
    rst_n = 1'b0;
    cfg_we = 0; cfg_addr = 0; cfg_data = 0; in_valid = 0; in_vec = 0; sweep_start = 0; out_ready = 0;
    cfg_we_2 = 0; cfg_addr_2 = 0; cfg_data_2 = 0; in_valid_2 = 0; in_vec_2 = 0; sweep_start_2 = 0; out_ready_2 = 0;
    for (int i = 0; i < 16; i++) model_lut[i] = 2'b00;

    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_vec", out_vec, 0);
    chk("rst_out_func", out_func, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    tick();

    // Narrow instance: XOR table swept end to end.
    xor_exp = '{2'd0, 2'd1, 2'd1, 2'd0};
    for (int a = 0; a < 4; a++) begin
      cfg_we_2 = 1'b1; cfg_addr_2 = 2'(a); cfg_data_2 = xor_exp[a][0];
      tick();
    end
    cfg_we_2 = 1'b0;
    sweep_start_2 = 1'b1; out_ready_2 = 1'b1;
    tick();
    sweep_start_2 = 1'b0;
    beats = 0;
    for (int c = 0; c < 20 && beats < 4; c++) begin
      if (out_valid_2) begin
        chk("n2_vec", out_vec_2, beats);
        chk("n2_func", out_func_2, xor_exp[beats]);
        chk("n2_last", out_last_2, (beats == 3) ? 1 : 0);
        beats++;
      end
      tick();
    end
    chk("n2_beats", beats, 4);
    chk("n2_idle", busy_2, 0);

    for (int a = 0; a < 16; a++) begin
      cfg_we = 1'b1; cfg_addr = 4'(a); cfg_data = ref_func(4'(a));
      model_lut[a] = ref_func(4'(a));
      tick();
    end
    cfg_we = 1'b0;

    tbl[0] = '{4'b0011, 2'b11};
    tbl[1] = '{4'b1000, 2'b10};
    tbl[2] = '{4'b0100, 2'b01};
    tbl[3] = '{4'b1111, 2'b10};
    tbl[4] = '{4'b0001, 2'b10};
    tbl[5] = '{4'b0110, 2'b10};
    tbl[6] = '{4'b0010, 2'b01};
    tbl[7] = '{4'b0000, 2'b00};
    for (int i = 0; i < 8; i++) begin
      eval4("tbl", tbl[i].vec, tbl[i].exp);
    end

    sweep4(1'b0, 1'b0);
    sweep4(1'b1, 1'b1);
    eval4("cfg_in_sweep", 4'd3, 2'b11);

    // Write and evaluate the same address together: old value first.
    cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 2'b00;
    in_valid = 1'b1; in_vec = 4'd3; out_ready = 1'b1;
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    chk("wr_eval_old", out_func, 2'b11);
    model_lut[3] = 2'b00;
    tick();
    eval4("wr_eval_new", 4'd3, 2'b00);

    for (int i = 0; i < 200; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_vec    = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_addr  = 4'($urandom);
      cfg_data  = 2'($urandom);
      #1;
      exp_free = (q_exp.size() == 0) || out_ready;
      chk("rand_valid", out_valid, (q_exp.size() != 0) ? 1 : 0);
      if (q_exp.size() != 0) begin
        chk("rand_vec", out_vec, q_exp[0][5:2]);
        chk("rand_func", out_func, q_exp[0][1:0]);
        if (out_ready) void'(q_exp.pop_front());
      end
      chk("rand_in_ready", in_ready, exp_free);
      if (in_valid && exp_free) q_exp.push_back({in_vec, model_lut[in_vec]});
      if (cfg_we) model_lut[cfg_addr] = cfg_data;
      tick();
    end
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    tick();

    // Reset in the middle of a sweep.
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    waited = 0;
    while (!(out_valid && out_vec == 4'd7) && waited < 40) begin
      tick();
      waited++;
    end
    chk("rst_sweep_reach7", (waited < 40) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) model_lut[i] = 2'b00;
    tick();
    eval4("post_rst_eval", 4'b0011, model_lut[3]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
